spi_prog_loader: RTL and testbench

- Controller for the chip's program-load path. Receives 16-bit instruction words over the 3-wire serial port (nCS, SCK, MOSI), writes them sequentially into program RAM from address 0, and holds the Forth CPU in reset while a load is in progress.
- Sits between the chip pins and the CPU/program-RAM write port. It is the only writer of program RAM after power-up.

---
 rtl/prog_loader_pkg.sv | 14 +
 rtl/sync_edge.sv | 38 +++
 rtl/spi_prog_loader.sv | 210 +++++++++++++++++++++
 tb/tb_spi_prog_loader.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared types and constants for the serial program loader
package prog_loader_pkg;

  // Instruction word width and the bit counter that frames it.
  localparam int WORD_W   = 16;
  localparam int BITCNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - multi-flop synchronizer with rise/fall detect
//
// Purpose: bring one asynchronous pin into the clk domain and flag its edges.
// Ports:
//   clk, rst_n  system clock, asynchronous active-low reset
//   d           asynchronous input
//   q           synchronized level (STAGES flops deep)
//   rise, fall  one-cycle pulses on a synchronized 0->1 / 1->0 change
module sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              q_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= {STAGES{RST_VAL}};
      q_d   <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      q_d   <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/spi_prog_loader.sv
// rtl/spi_prog_loader.sv - serial program loader: shifts in 16-bit words and writes program RAM
//
// Purpose: receives instruction words on nCS/SCK/MOSI, writes them to program
// RAM from address 0 and holds the CPU in reset during and shortly after a load.
// Ports:
//   clk, rst_n       system clock, asynchronous active-low reset
//   ncs, sck, mosi   serial pins (asynchronous), MSB first, sampled on sck rise
//   mem_we           one-cycle write strobe per received word
//   mem_addr         write address, restarts at 0 each session, never wraps
//   mem_wdata        write data
//   cpu_rst_n        CPU reset, low while loading and for RST_HOLD cycles after
//   loading          high while a session is active
//   word_count       words written in the current/last session
//   overflow         sticky: a complete word arrived with RAM already full
//   partial          sticky: the session ended mid-word
module spi_prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int DEPTH       = 512,
  parameter int SYNC_STAGES = 2,
  parameter int RST_HOLD    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ncs,
  input  logic              sck,
  input  logic              mosi,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_rst_n,
  output logic              loading,
  output logic [ADDR_W:0]   word_count,
  output logic              overflow,
  output logic              partial
);

  localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [7:0]        HOLD_INIT = 8'(RST_HOLD);

  // ---------------------------------------------------------------------------
  // Pin synchronizers
  // ---------------------------------------------------------------------------
  logic ncs_s, ncs_rise, ncs_fall;
  logic sck_s, sck_rise, sck_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .d(ncs),
    .q(ncs_s), .rise(ncs_rise), .fall(ncs_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst_n(rst_n), .d(sck),
    .q(sck_s), .rise(sck_rise), .fall(sck_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d(mosi),
    .q(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  // Only the ncs level, the sck rise and the mosi level drive the logic.
  logic unused_sync;
  assign unused_sync = ^{ncs_rise, ncs_fall, sck_s, sck_fall, mosi_rise, mosi_fall};

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t              state_q, state_d;
  logic [7:0]          hold_q, hold_d;
  logic [BITCNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0]   shift_q, shift_d;

  logic                mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic [WORD_W-1:0]   mem_wdata_d;
  logic                cpu_rst_n_d;
  logic                loading_d;
  logic [ADDR_W:0]     word_count_d;
  logic                overflow_d;
  logic                partial_d;

  logic [WORD_W-1:0]   shift_next;
  assign shift_next = {shift_q[WORD_W-2:0], mosi_s};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HOLD;
      hold_q     <= HOLD_INIT;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rst_n  <= 1'b0;
      loading    <= 1'b0;
      word_count <= '0;
      overflow   <= 1'b0;
      partial    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      mem_we     <= mem_we_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      cpu_rst_n  <= cpu_rst_n_d;
      loading    <= loading_d;
      word_count <= word_count_d;
      overflow   <= overflow_d;
      partial    <= partial_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    cpu_rst_n_d  = cpu_rst_n;
    loading_d    = loading;
    word_count_d = word_count;
    overflow_d   = overflow;
    partial_d    = partial;

    // Retire the write strobed last cycle. Independent of state so a word
    // completed just before ncs rises still advances the address and count.
    if (mem_we) begin
      word_count_d = word_count + (ADDR_W+1)'(1);
      if (mem_addr != LAST_ADDR) begin
        mem_addr_d = mem_addr + ADDR_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        cpu_rst_n_d = 1'b1;
        if (!ncs_s) begin
          state_d      = LOAD;
          loading_d    = 1'b1;
          cpu_rst_n_d  = 1'b0;
          mem_addr_d   = '0;
          bit_cnt_d    = '0;
          word_count_d = '0;
          overflow_d   = 1'b0;
          partial_d    = 1'b0;
        end
      end

      LOAD: begin
        cpu_rst_n_d = 1'b0;
        // ncs release wins over a coincident sck rise.
        if (ncs_s) begin
          if (bit_cnt_q != '0) begin
            partial_d = 1'b1;
          end
          bit_cnt_d = '0;
          state_d   = HOLD;
          hold_d    = HOLD_INIT;
          loading_d = 1'b0;
        end else if (sck_rise) begin
          shift_d   = shift_next;
          bit_cnt_d = bit_cnt_q + BITCNT_W'(1);
          if (bit_cnt_q == '1) begin
            if (word_count < DEPTH_C) begin
              mem_we_d    = 1'b1;
              mem_wdata_d = shift_next;
            end else begin
              overflow_d = 1'b1;
            end
          end
        end
      end

      HOLD: begin
        cpu_rst_n_d = 1'b0;
        if (!ncs_s) begin
          // Reload before the hold expires: CPU never leaves reset.
          state_d      = LOAD;
          loading_d    = 1'b1;
          mem_addr_d   = '0;
          bit_cnt_d    = '0;
          word_count_d = '0;
          overflow_d   = 1'b0;
          partial_d    = 1'b0;
        end else if (hold_q <= 8'd1) begin
          // Last hold cycle: release the CPU on the transition itself.
          hold_d      = '0;
          state_d     = IDLE;
          cpu_rst_n_d = 1'b1;
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end

      default: begin
        state_d = HOLD;
        hold_d  = HOLD_INIT;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_prog_loader.sv
// tb/tb_spi_prog_loader.sv - self-checking bench for spi_prog_loader
module tb_spi_prog_loader;

  localparam int ADDR_W   = 9;
  localparam int DEPTH    = 512;
  localparam int DEPTH4   = 4;
  localparam int SYNC     = 2;
  localparam int RST_HOLD = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ncs = 1'b1;
  logic sck = 1'b0;
  logic mosi = 1'b0;

  logic              mem_we, mem_we4;
  logic [ADDR_W-1:0] mem_addr, mem_addr4;
  logic [15:0]       mem_wdata, mem_wdata4;
  logic              cpu_rst_n, cpu_rst_n4;
  logic              loading, loading4;
  logic [ADDR_W:0]   word_count, word_count4;
  logic              overflow, overflow4;
  logic              partial, partial4;

  spi_prog_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .SYNC_STAGES(SYNC), .RST_HOLD(RST_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .ncs(ncs), .sck(sck), .mosi(mosi),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst_n(cpu_rst_n), .loading(loading), .word_count(word_count),
    .overflow(overflow), .partial(partial)
  );

  spi_prog_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH4), .SYNC_STAGES(SYNC), .RST_HOLD(RST_HOLD)) dut4 (
    .clk(clk), .rst_n(rst_n), .ncs(ncs), .sck(sck), .mosi(mosi),
    .mem_we(mem_we4), .mem_addr(mem_addr4), .mem_wdata(mem_wdata4),
    .cpu_rst_n(cpu_rst_n4), .loading(loading4), .word_count(word_count4),
    .overflow(overflow4), .partial(partial4)
  );

  always #20 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } wr_t;

  wr_t wq[$];
  wr_t wq4[$];
  bit  we_prev = 0, we4_prev = 0;
  int  double_we = 0;
  bit  watch = 0;
  int  cpu_hi_cnt = 0;

  // Write capture and strobe-width monitoring, sampled away from the active edge.
  always @(negedge clk) begin
    wr_t w;
    if (mem_we) begin
      w.addr = mem_addr; w.data = mem_wdata; wq.push_back(w);
    end
    if (mem_we4) begin
      w.addr = mem_addr4; w.data = mem_wdata4; wq4.push_back(w);
    end
    if (mem_we && we_prev) double_we++;
    if (mem_we4 && we4_prev) double_we++;
    we_prev = mem_we;
    we4_prev = mem_we4;
    if (watch && (cpu_rst_n || cpu_rst_n4)) cpu_hi_cnt++;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: actual %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic send_bit(input bit b);
    mosi = b;
    #50;
    sck = 1'b1;
    #50;
    sck = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Raise ncs and count clk cycles until both CPUs leave reset (bounded).
  task automatic end_session(output int k);
    #100;
    watch = 0;
    ncs = 1'b1;
    k = 0;
    while (!(cpu_rst_n && cpu_rst_n4) && k < 200) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_mem_we"}, int'(mem_we), 0);
    check({tag, "_mem_addr"}, int'(mem_addr), 0);
    check({tag, "_mem_wdata"}, int'(mem_wdata), 0);
    check({tag, "_cpu_rst_n"}, int'(cpu_rst_n), 0);
    check({tag, "_loading"}, int'(loading), 0);
    check({tag, "_word_count"}, int'(word_count), 0);
    check({tag, "_overflow"}, int'(overflow), 0);
    check({tag, "_partial"}, int'(partial), 0);
  endtask

  typedef struct {
    int nwords;   // complete words sent
    int nbits;    // trailing bits of one more word
    bit use_spec; // take data from the reference program instead of $urandom
    int exp_wc;   int exp_ovf;  int exp_part;
    int exp_wc4;  int exp_ovf4;
  } vec_t;

  vec_t tbl[7];
  logic [15:0] spec_words[19];
  logic [15:0] ram[DEPTH];

  initial begin
    int k;
    logic [15:0] wl[$];
    logic [15:0] w;

    spec_words = '{16'h8003, 16'h8101, 16'h0dc0, 16'h8002, 16'h8020, 16'h0840,
                   16'h600a, 16'h8001, 16'h01c0, 16'h4005, 16'h09c0, 16'h8003,
                   16'h04c0, 16'h0840, 16'h8100, 16'h0dc0, 16'h09c0, 16'h4004, 16'h0000};

    //         nw  nb spec  wc ovf part wc4 ovf4
    tbl[0] = '{18,  0, 1,  18, 0,  0,   4,  1};
    tbl[1] = '{ 1,  7, 1,   1, 0,  1,   1,  0};
    tbl[2] = '{ 6,  0, 0,   6, 0,  0,   4,  1};
    tbl[3] = '{ 3,  0, 0,   3, 0,  0,   3,  0};
    tbl[4] = '{ 4,  0, 0,   4, 0,  0,   4,  0};
    tbl[5] = '{ 5, 15, 0,   5, 0,  1,   4,  1};
    tbl[6] = '{ 0,  0, 0,   0, 0,  0,   0,  0};

    // Power-up
    wait_clks(3);
    check_reset_values("rst");
    rst_n = 1'b1;
    k = 0;
    while (!cpu_rst_n && k < 100) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("pwrup_hold_cycles", k, RST_HOLD);
    check("pwrup_no_write", wq.size() + wq4.size(), 0);
    wait_clks(3);

    // Table-driven sessions against the reference model
    for (int v = 0; v < 7; v++) begin
      int n_exp, n_exp4;
      wl.delete();
      for (int j = 0; j <= tbl[v].nwords; j++) begin
        w = tbl[v].use_spec ? spec_words[j] : 16'($urandom);
        wl.push_back(w);
      end
      wq.delete(); wq4.delete();
      double_we = 0; cpu_hi_cnt = 0;

      ncs = 1'b0;
      wait_clks(5);
      watch = 1;
      for (int j = 0; j < tbl[v].nwords; j++) send_word(wl[j]);
      for (int b = 0; b < tbl[v].nbits; b++) send_bit(wl[tbl[v].nwords][15-b]);
      end_session(k);
      wait_clks(2);

      n_exp  = (tbl[v].nwords < DEPTH)  ? tbl[v].nwords : DEPTH;
      n_exp4 = (tbl[v].nwords < DEPTH4) ? tbl[v].nwords : DEPTH4;

      check($sformatf("v%0d_writes", v), wq.size(), n_exp);
      check($sformatf("v%0d_writes4", v), wq4.size(), n_exp4);
      for (int j = 0; j < wq.size(); j++) begin
        check($sformatf("v%0d_addr%0d", v, j), int'(wq[j].addr), j);
        check($sformatf("v%0d_data%0d", v, j), int'(wq[j].data),
              (j < tbl[v].nwords) ? int'(wl[j]) : -1);
        ram[wq[j].addr] = wq[j].data;
      end
      for (int j = 0; j < wq4.size(); j++) begin
        check($sformatf("v%0d_addr4_%0d", v, j), int'(wq4[j].addr), j);
        check($sformatf("v%0d_data4_%0d", v, j), int'(wq4[j].data),
              (j < tbl[v].nwords) ? int'(wl[j]) : -1);
      end
      check($sformatf("v%0d_word_count", v), int'(word_count), tbl[v].exp_wc);
      check($sformatf("v%0d_overflow", v), int'(overflow), tbl[v].exp_ovf);
      check($sformatf("v%0d_partial", v), int'(partial), tbl[v].exp_part);
      check($sformatf("v%0d_word_count4", v), int'(word_count4), tbl[v].exp_wc4);
      check($sformatf("v%0d_overflow4", v), int'(overflow4), tbl[v].exp_ovf4);
      check($sformatf("v%0d_partial4", v), int'(partial4), tbl[v].exp_part);
      check($sformatf("v%0d_single_cycle_we", v), double_we, 0);
      check($sformatf("v%0d_cpu_held", v), cpu_hi_cnt, 0);
      check_range($sformatf("v%0d_release_delay", v), k, RST_HOLD + 1, RST_HOLD + SYNC + 2);
      check($sformatf("v%0d_loading_low", v), int'(loading), 0);
      if (tbl[v].exp_ovf4 != 0)
        check($sformatf("v%0d_addr4_nowrap", v), (mem_addr4 != '0) ? 1 : 0, 1);
      if (v == 0) begin
        check("prog_addr0", int'(ram[0]), 16'h8003);
        check("prog_addr17", int'(ram[17]), 16'h4004);
      end
      wait_clks(3);
    end

    // Reload during HOLD: ncs drops 2 cycles after the session ends
    begin
      logic [15:0] r0, r1, r2, r3;
      r0 = 16'($urandom); r1 = 16'($urandom); r2 = 16'($urandom); r3 = 16'($urandom);
      cpu_hi_cnt = 0;
      ncs = 1'b0;
      wait_clks(5);
      watch = 1;
      send_word(r0); send_word(r1); send_word(r2);
      #100;
      ncs = 1'b1;
      k = 0;
      while (loading && k < 50) begin
        @(negedge clk);
        k++;
      end
      check_range("reload_end_seen", k, 1, 49);
      wait_clks(2);
      wq.delete();
      ncs = 1'b0;
      wait_clks(5);
      send_word(r3); send_word(r0);
      end_session(k);
      wait_clks(2);
      check("reload_cpu_held", cpu_hi_cnt, 0);
      check("reload_writes", wq.size(), 2);
      if (wq.size() == 2) begin
        check("reload_addr0", int'(wq[0].addr), 0);
        check("reload_data0", int'(wq[0].data), int'(r3));
        check("reload_addr1", int'(wq[1].addr), 1);
        check("reload_data1", int'(wq[1].data), int'(r0));
      end
      check("reload_word_count", int'(word_count), 2);
      wait_clks(3);
    end

    // Abort: rst_n asserted mid-word 3
    begin
      logic [15:0] a2;
      a2 = 16'($urandom);
      wq.delete(); wq4.delete();
      ncs = 1'b0;
      wait_clks(5);
      send_word(16'($urandom)); send_word(16'($urandom));
      for (int b = 0; b < 5; b++) send_bit(a2[15-b]);
      rst_n = 1'b0;
      #1;
      check_reset_values("abort");
      for (int b = 5; b < 16; b++) send_bit(a2[15-b]);
      #100;
      ncs = 1'b1;
      wait_clks(5);
      check("abort_writes_during_rst", wq.size(), 2);
      rst_n = 1'b1;
      wait_clks(RST_HOLD + 5);
      check("abort_writes_after", wq.size(), 2);
      check("abort_cpu_released", int'(cpu_rst_n), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
